// File: rtl/toggle_stim_gen.sv
// Multi-channel square-wave / pulse stimulus generator with per-channel half-period,
// bounded or free-running runs, and an IDLE/RUN/DONE control FSM.
module toggle_stim_gen #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RUN_W = 24,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  input  logic [RUN_W-1:0] run_len,
  input  logic             start,
  input  logic             stop,
  output logic [NCH-1:0]   stim,
  output logic             busy,
  output logic             done,
  output logic [RUN_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_q [NCH];
  logic [CNT_W-1:0] half_d [NCH];
  logic [NCH-1:0]   mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   stim_q, stim_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [RUN_W-1:0] cycle_inc;
  logic             cfg_ok;

  assign cfg_ok    = cfg_we && (state_q != StRun) && (32'(cfg_ch) < NCH);
  assign cycle_inc = (cycle_cnt_q == {RUN_W{1'b1}}) ? cycle_cnt_q : cycle_cnt_q + RUN_W'(1);

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    run_len_d   = run_len_q;
    cycle_cnt_d = cycle_cnt_q;

    // Config only lands in shadow registers; channels read them on the next run.
    if (cfg_ok) begin
      half_d[cfg_ch] = cfg_half;
      mode_d[cfg_ch] = cfg_mode;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d     = StRun;
          run_len_d   = run_len;
          cycle_cnt_d = '0;
          stim_d      = '0;
          for (int unsigned i = 0; i < NCH; i++) cnt_d[i] = '0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          stim_d  = '0;
        end else begin
          cycle_cnt_d = cycle_inc;
          for (int unsigned i = 0; i < NCH; i++) begin
            if (half_q[i] == '0) begin
              cnt_d[i]  = '0;
              stim_d[i] = 1'b0;
            end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
              cnt_d[i]  = '0;
              stim_d[i] = mode_q[i] ? 1'b1 : ~stim_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if (mode_q[i]) stim_d[i] = 1'b0;
            end
          end
          if ((run_len_q != '0) && (cycle_inc == run_len_q)) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      stim_q      <= '0;
      run_len_q   <= '0;
      cycle_cnt_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        half_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stim_q      <= stim_d;
      run_len_q   <= run_len_d;
      cycle_cnt_q <= cycle_cnt_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign stim      = stim_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/toggle_stim_gen.md
TOGGLE_STIM_GEN -- requirements
Module: toggle_stim_gen

Interface
REQ-001 The block SHALL take these parameters:
- NCH, default 3: number of stimulus channels (1..32).
- CNT_W, default 16: width of each half-period value.
- RUN_W, default 24: width of the run-length and cycle counters.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- cfg_we, input, 1: config write strobe.
- cfg_ch, input, $clog2(NCH) (min 1): channel index for the write.
- cfg_half, input, CNT_W: half-period in clk cycles; 0 means channel disabled.
- cfg_mode, input, 1: 0 = toggle (square wave), 1 = pulse (one-cycle high per half-period).
- run_len, input, RUN_W: run length in cycles; 0 means free-run; sampled on start.
- start, input, 1: begin run.
- stop, input, 1: abort run.
- stim, output, NCH: stimulus outputs.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse at normal run completion.
- cycle_cnt, output, RUN_W: cycles elapsed in the current or last run.

Function
REQ-003 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-004 IDLE->RUN SHALL occur on an edge with start=1 and stop=0. That edge SHALL clear all channel counters, stim and cycle_cnt, and SHALL latch run_len.
REQ-005 In RUN, each enabled channel (half H>0) SHALL increment its counter every edge. When counter==H-1 the counter SHALL reload 0 and the channel SHALL fire.
REQ-006 On fire, a toggle-mode channel SHALL invert stim[i]. A pulse-mode channel SHALL drive stim[i]=1 for exactly that one cycle and 0 otherwise.
REQ-007 With start accepted at edge k, the first fire SHALL be visible after edge k+H. Toggle period SHALL be 2H cycles; pulse spacing SHALL be H cycles.
REQ-008 H=1 in toggle mode SHALL invert stim[i] every cycle. H=1 in pulse mode SHALL hold stim[i]=1 continuously.
REQ-009 A disabled channel (H=0) SHALL hold stim[i]=0 and its counter at 0.
REQ-010 cycle_cnt SHALL increment once per RUN edge and saturate at all-ones.
REQ-011 If latched run_len L>0, RUN->DONE SHALL occur on the edge where cycle_cnt becomes L; the run SHALL last exactly L edges.
REQ-012 In DONE, stim SHALL hold its last value, done=1 for that one cycle, and the next edge SHALL go to IDLE.
REQ-013 stop=1 in RUN SHALL go to IDLE on that edge, clear stim, not assert done, and leave cycle_cnt frozen.
REQ-014 Simultaneous start and stop SHALL be treated as stop. start while in RUN or DONE SHALL be ignored.
REQ-015 cfg_we while busy=1 SHALL be ignored. cfg_we with cfg_ch>=NCH SHALL be ignored. Otherwise the write SHALL take effect on the next run.
REQ-016 busy SHALL be 1 exactly in RUN. stim SHALL be 0 in IDLE except as held per REQ-017.
REQ-017 After DONE->IDLE, stim SHALL keep its DONE-state value until the next start or reset.

Reset
REQ-018 reset SHALL force IDLE, stim=0, busy=0, done=0, cycle_cnt=0, all counters 0, all cfg_half=0 and all cfg_mode=0.
REQ-019 reset SHALL take priority over every other input, including mid-run, and SHALL not produce a done pulse.

Verification
REQ-020 Bench SHALL cover: NCH=3, halves 1/5/10 toggle, run_len=300 -> stim periods 2/10/20 cycles, done pulses once at cycle 300, cycle_cnt=300.
REQ-021 Bench SHALL cover: ch1 pulse mode H=4, run_len=20 -> stim[1] high at cycles 4, 8, 12, 16, 20 relative to start.
REQ-022 Bench SHALL cover: stop at cycle 37 of a free-run (run_len=0) -> busy=0 next cycle, stim=0, done never asserted, cycle_cnt=37.
REQ-023 Bench SHALL cover: cfg_we ch0 H=7 while busy -> ignored, ch0 keeps its old half-period; same write while idle -> next run toggles every 7 cycles.
REQ-024 Bench SHALL cover: start and stop both high in IDLE -> stays IDLE; reset asserted at cycle 50 of a run -> all outputs 0 and cfg cleared next cycle.
REQ-025 Bench SHALL cover: channel H=0 -> stim[i]=0 for the whole run; H=1 pulse mode -> stim[i]=1 for the whole run.
